// File: rtl/cmos_tx_pkg.sv
// Shared types and helpers for the DVP-style RGB565 byte transmitter.
// Test-pattern colours are only used when CMOS_TX_TEST_PATTERN_EN is defined.
package cmos_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SYNC   = 3'd1,
      ST_BACK   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   // Truncating pack; the receiver zero-fills the dropped low bits.
   function automatic logic [15:0] pack565(input logic [23:0] rgb);
      return {rgb[23:19], rgb[15:10], rgb[7:3]};
   endfunction

   function automatic logic [23:0] bar_color(input logic [2:0] idx);
      logic [23:0] c;
      case (idx)
         3'd0:    c = 24'hFFFFFF;
         3'd1:    c = 24'hFFFF00;
         3'd2:    c = 24'h00FFFF;
         3'd3:    c = 24'h00FF00;
         3'd4:    c = 24'hFF00FF;
         3'd5:    c = 24'hFF0000;
         3'd6:    c = 24'h0000FF;
         default: c = 24'h000000;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cmos_16_8bit_tx_if.sv
// Pixel handshake plus DVP byte bus of the camera-emulator transmitter.
// master = transmitter side, slave = pixel source / bus observer.
interface cmos_16_8bit_tx_if;
   logic [23:0] pix_rgb888;
   logic        pix_valid;
   logic        pix_ready;
   logic [7:0]  pdata;
   logic        de;
   logic        vsync;

   modport master (input pix_rgb888, pix_valid, output pix_ready, pdata, de, vsync);
   modport slave  (output pix_rgb888, pix_valid, input pix_ready, pdata, de, vsync);
endinterface

// File: rtl/cmos_tx_timing.sv
// Frame timing: column/row counters, frame state machine, de window and byte phase.
// With CMOS_TX_TEST_PATTERN_EN defined it also exports the colour-bar index.
module cmos_tx_timing
   import cmos_tx_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int H_BLANK  = 16,
   parameter int V_SYNC   = 3,
   parameter int V_BACK   = 2,
   parameter int V_ACTIVE = 480,
   parameter int COL_W    = $clog2(2*H_ACTIVE+H_BLANK+1)
) (
   input  logic   i_pclk,
   input  logic   i_rst_n,
   input  logic   i_en,
   output state_e o_state,
   output logic   o_de_win,
   output logic   o_phase
`ifdef CMOS_TX_TEST_PATTERN_EN
   ,
   output logic [2:0] o_bar
`endif
);

   localparam int L     = 2*H_ACTIVE + H_BLANK;
   localparam int ROWS  = V_SYNC + V_BACK + V_ACTIVE;
   localparam int ROW_W = $clog2(ROWS+1);

   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(L-1);
   localparam logic [COL_W-1:0] DE_END    = COL_W'(2*H_ACTIVE);
   localparam logic [ROW_W-1:0] SYNC_LAST = ROW_W'(V_SYNC-1);
   localparam logic [ROW_W-1:0] BACK_LAST = ROW_W'(V_SYNC+V_BACK-1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS-1);

   state_e           state_d, state_q;
   logic [COL_W-1:0] col_d, col_q;
   logic [ROW_W-1:0] row_d, row_q;
   logic             phase_d, phase_q;
   logic             line_end, de_win;

   always_comb begin
      state_d  = state_q;
      col_d    = '0;
      row_d    = '0;
      line_end = (col_q == COL_LAST);
      de_win   = (state_q == ST_ACTIVE) && (col_q < DE_END);

      if (state_q inside {ST_SYNC, ST_BACK, ST_ACTIVE}) begin
         col_d = line_end ? '0 : col_q + 1'b1;
         row_d = row_q;
         if (line_end) row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end

      case (state_q)
         ST_IDLE:   if (i_en) state_d = ST_SYNC;
         ST_SYNC:   if (line_end && row_q == SYNC_LAST) state_d = ST_BACK;
         ST_BACK:   if (line_end && row_q == BACK_LAST) state_d = ST_ACTIVE;
         ST_ACTIVE: if (line_end && row_q == ROW_LAST) state_d = ST_DONE;
         ST_DONE:   state_d = i_en ? ST_SYNC : ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      // Blank cycles clear the phase, so every line starts on a high byte.
      phase_d = de_win ? ~phase_q : 1'b0;
   end

   always_ff @(posedge i_pclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         col_q   <= '0;
         row_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         phase_q <= phase_d;
      end
   end

   assign o_state  = state_q;
   assign o_de_win = de_win;
   assign o_phase  = phase_q;

`ifdef CMOS_TX_TEST_PATTERN_EN
   assign o_bar = 3'(((32'(col_q) >> 1) * 8) / H_ACTIVE);
`endif

endmodule

// File: rtl/cmos_16_8bit_tx.sv
// RGB888 -> RGB565 DVP byte transmitter (camera emulator), high byte first.
// Define CMOS_TX_TEST_PATTERN_EN to replace input pixels with 8 colour bars.
module cmos_16_8bit_tx
   import cmos_tx_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int H_BLANK  = 16,
   parameter int V_SYNC   = 3,
   parameter int V_BACK   = 2,
   parameter int V_ACTIVE = 480
) (
   input  logic              i_pclk,
   input  logic              i_rst_n,
   input  logic              i_en,
   cmos_16_8bit_tx_if.master bus,
   output logic              o_frame_done,
   output logic              o_underflow
);

   localparam int COL_W = $clog2(2*H_ACTIVE+H_BLANK+1);

   state_e      state;
   logic        de_win, phase, ready;
   logic [15:0] src565;
   logic        src_ok;
   logic [15:0] pix_d, pix_q;
   logic [7:0]  pdata_d, pdata_q;
   logic        de_d, de_q, vsync_d, vsync_q, done_d, done_q, unf_d, unf_q;

`ifdef CMOS_TX_TEST_PATTERN_EN
   logic [2:0] bar;
`endif

   cmos_tx_timing #(
      .H_ACTIVE (H_ACTIVE),
      .H_BLANK  (H_BLANK),
      .V_SYNC   (V_SYNC),
      .V_BACK   (V_BACK),
      .V_ACTIVE (V_ACTIVE),
      .COL_W    (COL_W)
   ) u_timing (
      .i_pclk   (i_pclk),
      .i_rst_n  (i_rst_n),
      .i_en     (i_en),
      .o_state  (state),
      .o_de_win (de_win),
      .o_phase  (phase)
`ifdef CMOS_TX_TEST_PATTERN_EN
      ,
      .o_bar    (bar)
`endif
   );

   always_comb begin
`ifdef CMOS_TX_TEST_PATTERN_EN
      ready  = 1'b0;
      src565 = pack565(bar_color(bar));
      src_ok = 1'b1;
`else
      ready  = de_win && !phase;
      src565 = pack565(bus.pix_rgb888);
      src_ok = bus.pix_valid;
`endif
      pix_d   = pix_q;
      pdata_d = 8'h00;
      unf_d   = unf_q;
      if (de_win) begin
         if (!phase) begin
            // A missing pixel still occupies its two byte slots, as zeros.
            pix_d   = src_ok ? src565 : 16'h0000;
            pdata_d = pix_d[15:8];
            if (!src_ok) unf_d = 1'b1;
         end else begin
            pdata_d = pix_q[7:0];
         end
      end
      de_d    = de_win;
      vsync_d = (state == ST_SYNC);
      done_d  = (state == ST_DONE);
   end

   always_ff @(posedge i_pclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pix_q   <= '0;
         pdata_q <= '0;
         de_q    <= 1'b0;
         vsync_q <= 1'b0;
         done_q  <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         pix_q   <= pix_d;
         pdata_q <= pdata_d;
         de_q    <= de_d;
         vsync_q <= vsync_d;
         done_q  <= done_d;
         unf_q   <= unf_d;
      end
   end

   assign bus.pix_ready = ready;
   assign bus.pdata     = pdata_q;
   assign bus.de        = de_q;
   assign bus.vsync     = vsync_q;
   assign o_frame_done  = done_q;
   assign o_underflow   = unf_q;

endmodule

// File: tb/tb_cmos_16_8bit_tx.sv
// Self-checking bench for cmos_16_8bit_tx with small frame parameters.
// Byte scoreboard from a vector table, framing counts, and a receiver-model loopback.
module tb_cmos_16_8bit_tx;

   localparam int HA = 4, HB = 2, VS = 1, VB = 1, VA = 2;

   typedef struct {
      logic [23:0] rgb;
      logic [7:0]  hi;
      logic [7:0]  lo;
   } vec_t;

   logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
   logic frame_done, underflow;
   always #5 clk = ~clk;

   cmos_16_8bit_tx_if bus();

   cmos_16_8bit_tx #(
      .H_ACTIVE (HA), .H_BLANK (HB), .V_SYNC (VS), .V_BACK (VB), .V_ACTIVE (VA)
   ) dut (
      .i_pclk       (clk),
      .i_rst_n      (rst_n),
      .i_en         (en),
      .bus          (bus.master),
      .o_frame_done (frame_done),
      .o_underflow  (underflow)
   );

   vec_t        vecs[9];
   int          checks = 0, errors = 0;
   logic [7:0]  exp_q[$];
   logic [23:0] pix_q[$];
   int          vi = 0, mode = 0;
   int          n_vs = 0, n_de = 0, n_fd = 0, run = 0, n_lb = 0;
   logic        prev_de = 1'b0, rx_ph = 1'b0;
   logic [7:0]  rx_hi = 8'h00;
   logic [23:0] cur_pix = 24'h0;
   logic [7:0]  cur_hi = 8'h00, cur_lo = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_pix();
      if (mode == 0) begin
         cur_pix = vecs[vi].rgb;
         cur_hi  = vecs[vi].hi;
         cur_lo  = vecs[vi].lo;
         vi      = (vi + 1) % 9;
      end else begin
         cur_pix = 24'($urandom());
      end
      bus.pix_rgb888 = cur_pix;
   endtask

   task automatic clr_stats();
      n_vs = 0; n_de = 0; n_fd = 0;
   endtask

   // One clock: observe at negedge, then return just after the next posedge.
   task automatic tick();
      logic hs, acc;
      logic [23:0] got;
      @(negedge clk);
      if (bus.de) begin
         run++;
         if (mode == 0) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL byte: unexpected de byte %0h at %0t", bus.pdata, $time);
            end else begin
               chk("byte", 32'(bus.pdata), 32'(exp_q.pop_front()));
            end
         end else begin
            if (!rx_ph) begin
               rx_hi = bus.pdata;
            end else if (pix_q.size() != 0) begin
               got = {rx_hi[7:3], 3'b000, rx_hi[2:0], bus.pdata[7:5], 2'b00, bus.pdata[4:0], 3'b000};
               chk("loopback", 32'(got), 32'(pix_q.pop_front() & 24'hF8FCF8));
               n_lb++;
            end
            rx_ph = ~rx_ph;
         end
      end else begin
         if (prev_de) chk("de_run", run, 2*HA);
         run   = 0;
         rx_ph = 1'b0;
      end
      prev_de = bus.de;
      n_vs += int'(bus.vsync);
      n_de += int'(bus.de);
      n_fd += int'(frame_done);
      hs  = bus.pix_ready;
      acc = hs && bus.pix_valid;
      if (hs) begin
         if (mode == 0) begin
            exp_q.push_back(acc ? cur_hi : 8'h00);
            exp_q.push_back(acc ? cur_lo : 8'h00);
         end else begin
            pix_q.push_back(acc ? cur_pix : 24'h0);
         end
      end
      @(posedge clk);
      #1;
      if (acc) set_pix();
   endtask

   task automatic wait_fd(input string name, input int max);
      int f0;
      f0 = n_fd;
      for (int i = 0; i < max && n_fd == f0; i++) tick();
      chk(name, 32'(n_fd != f0), 32'd1);
   endtask

   initial begin
      int k;
      vecs[0] = '{24'hF8FCF8, 8'hFF, 8'hFF};
      vecs[1] = '{24'h123456, 8'h11, 8'hAA};
      vecs[2] = '{24'h000000, 8'h00, 8'h00};
      vecs[3] = '{24'hFFFFFF, 8'hFF, 8'hFF};
      vecs[4] = '{24'h808080, 8'h84, 8'h10};
      vecs[5] = '{24'h0F0F0F, 8'h08, 8'h61};
      vecs[6] = '{24'hFF0000, 8'hF8, 8'h00};
      vecs[7] = '{24'h00FF00, 8'h07, 8'hE0};
      vecs[8] = '{24'h0000FF, 8'h00, 8'h1F};

      bus.pix_valid  = 1'b0;
      bus.pix_rgb888 = 24'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pdata", 32'(bus.pdata), 0);
      chk("rst_de", 32'(bus.de), 0);
      chk("rst_vsync", 32'(bus.vsync), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_underflow", 32'(underflow), 0);
      chk("rst_ready", 32'(bus.pix_ready), 0);

      // Two full frames of table vectors.
      en = 1'b1;
      bus.pix_valid = 1'b1;
      set_pix();
      @(negedge clk);
      rst_n = 1'b1;
      for (int f = 0; f < 2; f++) begin
         clr_stats();
         wait_fd("frame_done", 100);
         chk("vsync_cycles", n_vs, 10);
         chk("de_cycles", n_de, 16);
         chk("frame_done_pulses", n_fd, 1);
      end
      chk("no_underflow", 32'(underflow), 0);

      // Miss the third pixel of the next frame.
      clr_stats();
      k = 0;
      for (int i = 0; i < 100 && k < 3; i++) begin
         tick();
         if (bus.pix_ready) k++;
      end
      chk("found_ready", k, 3);
      bus.pix_valid = 1'b0;
      tick();
      bus.pix_valid = 1'b1;
      wait_fd("underflow_frame_done", 100);
      chk("underflow_set", 32'(underflow), 1);
      chk("underflow_de_cycles", n_de, 16);
      chk("underflow_vsync_cycles", n_vs, 10);

      // Drop enable mid-frame: this frame finishes, then silence.
      clr_stats();
      for (int i = 0; i < 100 && !bus.de; i++) tick();
      chk("de_before_disable", 32'(bus.de), 1);
      en = 1'b0;
      wait_fd("disable_frame_done", 100);
      clr_stats();
      repeat (60) tick();
      chk("idle_vsync", n_vs, 0);
      chk("idle_de", n_de, 0);
      chk("underflow_sticky", 32'(underflow), 1);

      // Reset in the middle of an active line.
      en = 1'b1;
      for (int i = 0; i < 100 && !bus.de; i++) tick();
      chk("de_before_reset", 32'(bus.de), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_de", 32'(bus.de), 0);
      chk("async_rst_pdata", 32'(bus.pdata), 0);
      chk("async_rst_vsync", 32'(bus.vsync), 0);
      chk("async_rst_underflow", 32'(underflow), 0);
      exp_q.delete();
      pix_q.delete();
      prev_de = 1'b0;
      run     = 0;
      rx_ph   = 1'b0;
      mode    = 1;
      set_pix();
      @(negedge clk);
      rst_n = 1'b1;
      clr_stats();
      for (int i = 0; i < 50 && !bus.vsync && !bus.de; i++) tick();
      chk("restart_vsync_first", 32'({bus.vsync, bus.de}), 32'b10);

      // Loopback through a receiver model.
      for (int i = 0; i < 200 && n_lb < 8; i++) tick();
      chk("loopback_pixels", 32'(n_lb >= 8), 1);
      chk("loopback_underflow", 32'(underflow), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
